core_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32E NPC datapath. It owns the PC register and steps each instruction through fetch, decode, execute, memory and writeback. It gates the register-file write enable and jump/PC update produced by the decoder, and halts the core on ebreak, illegal opcode or handshake timeout.

---
 rtl/core_seq_pkg.sv | 29 ++
 rtl/core_seq_wdog.sv | 28 ++
 rtl/core_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// Shared encodings for the core_seq_ctrl sequencer slice:
// state codes, halt codes and PC constants.
package core_seq_pkg;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   typedef enum logic [2:0] {
      S_FETCH  = ST_FETCH,
      S_DECODE = ST_DECODE,
      S_EXEC   = ST_EXEC,
      S_MEM    = ST_MEM,
      S_WB     = ST_WB,
      S_HALT   = ST_HALT
   } state_t;

   localparam logic [1:0] HALT_EBREAK  = 2'd0;
   localparam logic [1:0] HALT_ILLEGAL = 2'd1;
   localparam logic [1:0] HALT_TIMEOUT = 2'd2;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [31:0] PC_INC       = 32'h4;
   localparam logic [31:0] JUMP_MASK    = 32'hFFFF_FFFE;

endpackage

// File: rtl/core_seq_wdog.sv
// Clearable handshake wait counter for core_seq_ctrl.
// tc marks the wait cycle whose miss would bring the count to 2^TIMEOUT_W-1.
module core_seq_wdog #(
   parameter int TIMEOUT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   localparam logic [TIMEOUT_W-1:0] ONES = '1;
   localparam logic [TIMEOUT_W-1:0] LAST = ONES - TIMEOUT_W'(1);

   logic [TIMEOUT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + TIMEOUT_W'(1);
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC.
// Optional perf counters enabled by defining CORE_SEQ_PERF_EN.
module core_seq_ctrl
   import core_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_o,
   output logic        ifu_req_o,
   input  logic        ifu_rvalid_i,
   output logic        ir_we_o,
   input  logic        dec_rf_we_i,
   input  logic        dec_jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        dec_load_i,
   input  logic        dec_store_i,
   input  logic        dec_ebreak_i,
   input  logic        dec_illegal_i,
   output logic        lsu_req_o,
   output logic        lsu_we_o,
   input  logic        lsu_ack_i,
   output logic        rf_we_o,
   output logic        halt_o,
   output logic [1:0]  halt_code_o
`ifdef CORE_SEQ_PERF_EN
   ,
   output logic [63:0] cycle_cnt_o,
   output logic [63:0] instret_o
`endif
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [1:0]  code;
   logic [1:0]  code_nxt;
   logic        wd_clr;
   logic        wd_inc;
   logic        wd_tc;

   core_seq_wdog #(
      .TIMEOUT_W (TIMEOUT_W)
   ) u_wdog (
      .clk (clk),
      .rst (rst),
      .clr (wd_clr),
      .inc (wd_inc),
      .tc  (wd_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         code  <= HALT_EBREAK;
      end else begin
         state <= state_nxt;
         code  <= code_nxt;
         if (state == S_WB) begin
            pc <= dec_jump_i ? (jump_target_i & JUMP_MASK)
                             : pc + PC_INC;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      code_nxt  = code;
      ifu_req_o = 1'b0;
      ir_we_o   = 1'b0;
      lsu_req_o = 1'b0;
      lsu_we_o  = 1'b0;
      rf_we_o   = 1'b0;
      wd_clr    = 1'b1;
      wd_inc    = 1'b0;
      unique case (state)
         S_FETCH: begin
            ifu_req_o = 1'b1;
            wd_clr    = 1'b0;
            if (ifu_rvalid_i) begin
               ir_we_o   = 1'b1;
               state_nxt = S_DECODE;
            end else if (wd_tc) begin
               state_nxt = S_HALT;
               code_nxt  = HALT_TIMEOUT;
            end else begin
               wd_inc = 1'b1;
            end
         end
         S_DECODE: begin
            if (dec_illegal_i) begin
               state_nxt = S_HALT;
               code_nxt  = HALT_ILLEGAL;
            end else if (dec_ebreak_i) begin
               state_nxt = S_HALT;
               code_nxt  = HALT_EBREAK;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            state_nxt = (dec_load_i || dec_store_i) ? S_MEM : S_WB;
         end
         S_MEM: begin
            lsu_req_o = 1'b1;
            lsu_we_o  = dec_store_i;
            wd_clr    = 1'b0;
            if (lsu_ack_i) begin
               state_nxt = S_WB;
            end else if (wd_tc) begin
               state_nxt = S_HALT;
               code_nxt  = HALT_TIMEOUT;
            end else begin
               wd_inc = 1'b1;
            end
         end
         S_WB: begin
            rf_we_o   = dec_rf_we_i & ~dec_store_i;
            state_nxt = S_FETCH;
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_FETCH;
         end
      endcase
   end

   assign pc_o        = pc;
   assign halt_o      = (state == S_HALT);
   assign halt_code_o = code;

`ifdef CORE_SEQ_PERF_EN
   logic [63:0] cyc_cnt;
   logic [63:0] ret_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt <= '0;
         ret_cnt <= '0;
      end else begin
         if (state != S_HALT) begin
            cyc_cnt <= cyc_cnt + 64'd1;
         end
         if (state == S_WB) begin
            ret_cnt <= ret_cnt + 64'd1;
         end
      end
   end

   assign cycle_cnt_o = cyc_cnt;
   assign instret_o   = ret_cnt;
`else
   // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl with TIMEOUT_W=4.
// Expected per-instruction outcomes are queued at issue and popped on completion.
module tb_core_seq_ctrl;
   import core_seq_pkg::*;

   localparam int          TW  = 4;
   localparam int          TMO = (1 << TW) - 1;
   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc;
   logic        ifu_req;
   logic        ifu_rvalid = 1'b0;
   logic        ir_we;
   logic        dec_rf_we = 1'b0;
   logic        dec_jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic        dec_load = 1'b0;
   logic        dec_store = 1'b0;
   logic        dec_ebreak = 1'b0;
   logic        dec_illegal = 1'b0;
   logic        lsu_req;
   logic        lsu_we;
   logic        lsu_ack = 1'b0;
   logic        rf_we;
   logic        halt;
   logic [1:0]  halt_code;
`ifdef CORE_SEQ_PERF_EN
   logic [63:0] cyc_cnt;
   logic [63:0] instret;
`endif

   always #5 clk = ~clk;

   core_seq_ctrl #(
      .RESET_PC  (RPC),
      .TIMEOUT_W (TW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_o          (pc),
      .ifu_req_o     (ifu_req),
      .ifu_rvalid_i  (ifu_rvalid),
      .ir_we_o       (ir_we),
      .dec_rf_we_i   (dec_rf_we),
      .dec_jump_i    (dec_jump),
      .jump_target_i (jump_target),
      .dec_load_i    (dec_load),
      .dec_store_i   (dec_store),
      .dec_ebreak_i  (dec_ebreak),
      .dec_illegal_i (dec_illegal),
      .lsu_req_o     (lsu_req),
      .lsu_we_o      (lsu_we),
      .lsu_ack_i     (lsu_ack),
      .rf_we_o       (rf_we),
      .halt_o        (halt),
      .halt_code_o   (halt_code)
`ifdef CORE_SEQ_PERF_EN
      ,
      .cycle_cnt_o   (cyc_cnt),
      .instret_o     (instret)
`endif
   );

   typedef struct {
      string       tag;
      logic [31:0] pc;
      int          rfw;
      int          rfw_at;
      int          cyc;
      int          memc;
      int          wec;
      logic        halt;
      logic [1:0]  code;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mpc;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_dec();
      dec_rf_we   = 1'b0;
      dec_jump    = 1'b0;
      jump_target = '0;
      dec_load    = 1'b0;
      dec_store   = 1'b0;
      dec_ebreak  = 1'b0;
      dec_illegal = 1'b0;
      ifu_rvalid  = 1'b0;
      lsu_ack     = 1'b0;
   endtask

   task automatic do_rst();
      rst = 1'b1;
      clr_dec();
      @(negedge clk);
      rst = 1'b0;
      mpc = RPC;
   endtask

   // Issue one instruction; returns in the FETCH cycle that follows it.
   task automatic run_instr(input string tag, input logic rfwe,
                            input logic jmp, input logic ld,
                            input logic st, input logic eb,
                            input logic il, input logic [31:0] tgt,
                            input int rvd, input int ackd);
      exp_t e;
      exp_t g;
      logic mem;
      int   n, memc, wec, rfw, rfw_at;
      bit   acc, done;
      mem      = ld | st;
      e.tag    = tag;
      e.halt   = 1'b0;
      e.code   = HALT_EBREAK;
      e.rfw    = 0;
      e.rfw_at = 0;
      e.memc   = 0;
      e.wec    = 0;
      e.pc     = mpc;
      if (il || eb) begin
         e.halt = 1'b1;
         e.code = il ? HALT_ILLEGAL : HALT_EBREAK;
         e.cyc  = 2;
      end else if (mem && ackd >= TMO) begin
         e.halt = 1'b1;
         e.code = HALT_TIMEOUT;
         e.cyc  = 3 + TMO;
         e.memc = TMO;
         e.wec  = st ? TMO : 0;
      end else begin
         e.memc = mem ? ackd + 1 : 0;
         e.wec  = st ? e.memc : 0;
         e.cyc  = mem ? 5 + ackd : 4;
         if (rfwe && !st) begin
            e.rfw    = 1;
            e.rfw_at = e.cyc;
         end
         e.pc = jmp ? {tgt[31:1], 1'b0} : mpc + 32'h4;
      end
      mpc = e.pc;
      sb.push_back(e);

      dec_rf_we   = rfwe;
      dec_jump    = jmp;
      jump_target = tgt;
      dec_load    = ld;
      dec_store   = st;
      dec_ebreak  = eb;
      dec_illegal = il;
      acc = 0; done = 0;
      n = 0; memc = 0; wec = 0; rfw = 0; rfw_at = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         ifu_rvalid = !acc && (c >= rvd);
         lsu_ack    = 1'b0;
         #1;
         if (lsu_req) begin
            lsu_ack = (memc == ackd);
            memc++;
            if (lsu_we) wec++;
         end
         #1;
         if (ir_we) acc = 1;
         if (acc) n++;
         if (rf_we) begin
            rfw++;
            rfw_at = n;
         end
         if (halt || (acc && n > 1 && ifu_req)) done = 1;
         else @(negedge clk);
      end
      clr_dec();

      g = sb.pop_front();
      chk({g.tag, "_done"}, 64'(done), 64'd1);
      chk({g.tag, "_cyc"}, n - 1, g.cyc);
      chk({g.tag, "_pc"}, pc, g.pc);
      chk({g.tag, "_rfw"}, rfw, g.rfw);
      chk({g.tag, "_rfw_at"}, rfw_at, g.rfw_at);
      chk({g.tag, "_memc"}, memc, g.memc);
      chk({g.tag, "_wec"}, wec, g.wec);
      chk({g.tag, "_halt"}, halt, g.halt);
      if (g.halt) chk({g.tag, "_code"}, halt_code, g.code);
   endtask

   initial begin
      int  fc;
      bit  h;
      bit  seen;
      do_rst();
      #1;
      chk("rst_pc", pc, RPC);
      chk("rst_halt", halt, 1'b0);
      chk("rst_code", halt_code, 2'd0);
      chk("rst_ifu_req", ifu_req, 1'b1);
      chk("rst_ir_we", ir_we, 1'b0);
      chk("rst_lsu_req", lsu_req, 1'b0);
      chk("rst_rf_we", rf_we, 1'b0);

      run_instr("addi", 1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
      run_instr("jal", 1, 1, 0, 0, 0, 0, 32'h8000_0101, 0, 0);
      run_instr("sw_d3", 1, 0, 0, 1, 0, 0, 32'h0, 0, 3);
      run_instr("lw", 1, 0, 1, 0, 0, 0, 32'h0, 2, 0);
      run_instr("jal_top", 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFD, 0, 0);
      run_instr("wrap", 1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
      run_instr("lw_ack_tc", 1, 0, 1, 0, 0, 0, 32'h0, 0, TMO - 1);
      run_instr("eb_ill", 1, 0, 0, 0, 1, 1, 32'h0, 0, 0);

      for (int i = 0; i < 4; i++) begin
         ifu_rvalid = 1'b1;
         lsu_ack    = 1'b1;
         @(negedge clk);
      end
      #1;
      chk("stuck_halt", halt, 1'b1);
      chk("stuck_code", halt_code, HALT_ILLEGAL);
      chk("stuck_ifu_req", ifu_req, 1'b0);
      chk("stuck_ir_we", ir_we, 1'b0);
      chk("stuck_pc", pc, mpc);
      clr_dec();

      do_rst();
      run_instr("fetch_tc_win", 1, 0, 0, 0, 0, 0, 32'h0, TMO - 1, 0);

      do_rst();
      fc = 0;
      h  = 0;
      for (int i = 0; i < 100 && !h; i++) begin
         #1;
         if (halt) h = 1;
         else begin
            if (ifu_req) fc++;
            @(negedge clk);
         end
      end
      chk("to_halt", 64'(h), 64'd1);
      chk("to_waits", fc, TMO);
      chk("to_code", halt_code, HALT_TIMEOUT);
      chk("to_pc", pc, RPC);
      do_rst();
      #1;
      chk("to_rst_pc", pc, RPC);
      chk("to_rst_halt", halt, 1'b0);

      do_rst();
      run_instr("sw_to", 0, 0, 0, 1, 0, 0, 32'h0, 0, TMO);

      do_rst();
      run_instr("pre_mem", 1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
      dec_store = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         ifu_rvalid = 1'b1;
         #1;
         if (lsu_req) seen = 1;
         else @(negedge clk);
      end
      chk("mrst_seen", 64'(seen), 64'd1);
      do_rst();
      #1;
      chk("mrst_lsu_req", lsu_req, 1'b0);
      chk("mrst_ifu_req", ifu_req, 1'b1);
      chk("mrst_pc", pc, RPC);
      chk("mrst_halt", halt, 1'b0);
`ifdef CORE_SEQ_PERF_EN
      chk("mrst_cyc_cnt", cyc_cnt, 64'd0);
      chk("mrst_instret", instret, 64'd0);
`endif

      run_instr("ebreak", 1, 0, 0, 0, 1, 0, 32'h0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
